// File: rtl/led_blink_ctrl.sv
// Multi-channel LED pattern controller: NUM_CH channels (OFF/ON/BLINK/ONESHOT)
// paced by one shared prescaler tick and configured through a single write port.
module led_blink_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 50_000,
  parameter int CNT_W    = 10,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] oneshot_done
);

  localparam int               PRE_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(PRESCALE - 1);
  localparam logic [CH_W:0]    NUM_CH_V     = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       MODE_OFF     = 2'd0;
  localparam logic [1:0]       MODE_BLINK   = 2'd2;
  localparam logic [1:0]       MODE_ONESHOT = 2'd3;

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick_s;
  logic              wr_hit_s;
  logic [1:0]        mode_q [NUM_CH];
  logic [1:0]        mode_d [NUM_CH];
  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  half_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic [NUM_CH-1:0] done_q, done_d;

  // A programmed half-period of zero is treated as one tick.
  function automatic logic [CNT_W-1:0] heff_f(input logic [CNT_W-1:0] half);
    return (half == '0) ? CNT_ONE : half;
  endfunction

  // State register for prescaler and all channel state
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      led_q     <= '0;
      done_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= CNT_ONE;
        cnt_q[i]  <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      led_q     <= led_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
    end
  end

  // Prescaler: free-running while enabled, frozen otherwise
  always_comb begin
    tick_s    = enable && (pre_cnt_q == PRE_LAST);
    pre_cnt_d = pre_cnt_q;
    if (enable) begin
      if (tick_s) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  // Channel next-state: a write to a channel pre-empts its tick in the same cycle
  always_comb begin
    wr_hit_s = wr_en && ({1'b0, wr_ch} < NUM_CH_V);
    led_d    = led_q;
    done_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      if (wr_hit_s && (wr_ch == CH_W'(i))) begin
        mode_d[i] = wr_mode;
        half_d[i] = wr_half;
        cnt_d[i]  = '0;
        led_d[i]  = (wr_mode != MODE_OFF);
      end else if (tick_s) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (cnt_q[i] == heff_f(half_q[i]) - CNT_ONE) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q[i] == heff_f(half_q[i]) - CNT_ONE) begin
              cnt_d[i]  = '0;
              led_d[i]  = 1'b0;
              mode_d[i] = MODE_OFF;
              done_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            cnt_d[i] = '0;
          end
        endcase
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    led          = led_q;
    oneshot_done = done_q;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomized and directed bench for led_blink_ctrl, checked every cycle against
// a tick-counting behavioural model plus hand-computed timing expectations.
module tb_led_blink_ctrl;

  localparam int NCH = 4;
  localparam int PS  = 4;
  localparam int OFF = 0, ON = 1, BLINK = 2, ONESHOT = 3;

  logic       clk = 1'b0;
  logic       rst, enable, wr_en;
  logic [1:0] wr_ch, wr_mode;
  logic [3:0] wr_half;
  logic [3:0] led, oneshot_done;
  logic [2:0] led3, done3;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Model: prescaler position and, per channel, ticks seen since the last write
  int         m_pre = 0;
  int         m_mode [NCH];
  int         m_heff [NCH];
  int         m_n    [NCH];
  logic [3:0] m_led  = '0;
  logic [3:0] m_done = '0;

  led_blink_ctrl #(.NUM_CH(4), .PRESCALE(PS), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_half(wr_half), .led(led), .oneshot_done(oneshot_done)
  );

  led_blink_ctrl #(.NUM_CH(3), .PRESCALE(PS), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_half(wr_half), .led(led3), .oneshot_done(done3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_update();
    bit tk;
    if (rst) begin
      m_pre  = 0;
      m_led  = '0;
      m_done = '0;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = OFF; m_heff[i] = 1; m_n[i] = 0;
      end
    end else begin
      tk = enable && (m_pre == PS - 1);
      if (enable) m_pre = (m_pre + 1) % PS;
      m_done = '0;
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && (int'(wr_ch) == i)) begin
          m_mode[i] = int'(wr_mode);
          m_heff[i] = (wr_half == 4'd0) ? 1 : int'(wr_half);
          m_n[i]    = 0;
          m_led[i]  = (wr_mode != 2'd0);
        end else if (tk && m_mode[i] == BLINK) begin
          m_n[i]++;
          m_led[i] = ((m_n[i] / m_heff[i]) % 2) == 0;
        end else if (tk && m_mode[i] == ONESHOT) begin
          m_n[i]++;
          if (m_n[i] == m_heff[i]) begin
            m_mode[i] = OFF; m_led[i] = 1'b0; m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int mode, input int half);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_mode = 2'(mode);
    wr_half = 4'(half);
    step();
    wr_en = 1'b0;
  endtask

  // Number of cycles led[ch] stays at lvl, bounded by maxc
  task automatic measure(input int ch, input logic lvl, input int maxc, output int n);
    n = 0;
    while ((led[ch] == lvl) && (n < maxc)) begin
      step();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("led_vs_model", int'(led), int'(m_led));
      check("done_vs_model", int'(oneshot_done), int'(m_done));
    end
  end

  initial begin
    int n, n2, g;
    logic [3:0] seen;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = OFF; m_heff[i] = 1; m_n[i] = 0;
    end
    rst = 1'b1; enable = 1'b1; wr_en = 1'b1;
    wr_ch = 2'd0; wr_mode = 2'd2; wr_half = 4'd3;
    @(negedge clk);
    step();
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_led", int'(led), 0);
      check("rst_done", int'(oneshot_done), 0);
      step();
    end
    rst = 1'b0; wr_en = 1'b0;
    repeat (8) step();
    check("post_rst_idle", int'(led), 0);

    wr(3, ON, 0);
    check("nch3_ignore_ch3", int'(led3), 0);
    check("ch3_on_main", int'(led[3]), 1);
    wr(1, ON, 0);
    check("nch3_ch1_on", int'(led3), 2);
    wr(1, OFF, 0);
    wr(3, OFF, 0);

    wr(0, BLINK, 3);
    check("blink_on_next", int'(led[0]), 1);
    check("model_blink_on", int'(m_led[0]), 1);
    measure(0, 1'b1, 20, n);
    check("blink_first_9_12", int'(n >= 9 && n <= 12), 1);
    measure(0, 1'b0, 30, n);
    check("blink_low_12", n, 12);
    measure(0, 1'b1, 30, n);
    check("blink_high_12", n, 12);

    wr(2, ONESHOT, 2);
    check("oneshot_on", int'(led[2]), 1);
    measure(2, 1'b1, 20, n);
    check("oneshot_len_5_8", int'(n >= 5 && n <= 8), 1);
    check("oneshot_done_at_fall", int'(oneshot_done[2]), 1);
    step();
    check("oneshot_done_1cyc", int'(oneshot_done[2]), 0);
    seen = '0;
    repeat (20) begin step(); seen |= oneshot_done; seen[2] |= led[2]; end
    check("oneshot_quiet", int'(seen[2]), 0);

    wr(1, BLINK, 1);
    measure(1, 1'b1, 10, n);
    step(); step();
    enable = 1'b0;
    repeat (20) step();
    check("freeze_led_hold", int'(led[1]), 0);
    enable = 1'b1;
    measure(1, 1'b0, 40, n2);
    check("freeze_half_24", 2 + 20 + n2, 24);
    measure(1, 1'b1, 10, n);
    check("freeze_resume_4", n, 4);

    g = 0;
    while (m_pre != PS - 1 && g < 10) begin step(); g++; end
    wr(3, BLINK, 2);
    measure(3, 1'b1, 20, n);
    check("wr_tick_restart_8", n, 8);

    wr(3, BLINK, 0);
    measure(3, 1'b1, 10, n);
    check("half0_first_1_4", int'(n >= 1 && n <= 4), 1);
    measure(3, 1'b0, 10, n);
    check("half0_period_4", n, 4);

    wr(0, BLINK, 2);
    wr(2, ONESHOT, 3);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_led", int'(led), 0);
    check("midrst_done", int'(oneshot_done), 0);
    seen = '0;
    repeat (30) begin step(); seen |= oneshot_done | led; end
    check("midrst_quiet", int'(seen), 0);

    repeat (600) begin
      enable  = ($urandom_range(0, 7) != 0);
      rst     = ($urandom_range(0, 149) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_mode = 2'($urandom_range(0, 3));
      wr_half = 4'($urandom_range(0, 4));
      step();
    end
    rst = 1'b0; wr_en = 1'b0; enable = 1'b1;
    step();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Multi-channel LED pattern controller. It generalises the single-output toggle blinker to NUM_CH independent channels, each with a run-time mode and a half-period setting. A shared prescaler produces a timebase tick, and per-channel counters run on that tick. A simple register-write port configures the channels, and a global enable freezes all timing. The block sits between board-level control logic and the LED pins.

Parameters:
NUM_CH, 4, number of LED channels (≥1)
PRESCALE, 50_000, clk cycles per tick (≥1); 1 ms at 50 MHz
CNT_W, 10, width of the per-channel half-period, in ticks
CH_W, derived = max(1, clog2(NUM_CH)), width of the channel select

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  global run; 0 freezes prescaler and all channel counters
wr_en  in  1  write strobe for channel configuration
wr_ch  in  CH_W  target channel of write
wr_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT
wr_half  in  CNT_W  half-period in ticks
led  out  NUM_CH  registered LED drive, bit i = channel i
oneshot_done  out  NUM_CH  1-cycle pulse when channel i ends a ONESHOT

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). rst overrides wr_en, enable and ticks.
- Reset values: led=0, oneshot_done=0, prescaler=0; every channel has mode=OFF, half=1, cnt=0.
- Prescaler: pre_cnt counts 0..PRESCALE-1 while enable=1 and wraps to 0. tick=1 in the cycle where pre_cnt==PRESCALE-1 and enable=1. With PRESCALE=1, tick=1 on every enabled cycle.
- enable=0: pre_cnt holds, no tick occurs, and all cnt and led values hold. Writes are still accepted.
- Channel writes are not affected by enable. The prescaler is never reset by a write.
- Effective half-period: heff = (half==0) ? 1 : half.
- Write, when wr_en=1 and wr_ch<NUM_CH, at the next edge:
  - mode<=wr_mode, half<=wr_half, cnt<=0.
  - led<=0 for OFF; led<=1 for ON, BLINK and ONESHOT.
  - If wr_ch≥NUM_CH, the write is ignored with no side effects.
- Write vs tick in the same cycle on the same channel: the write wins and the tick is lost for that channel. Other channels process the tick normally.
- On tick, per channel:
  - OFF / ON: cnt stays 0 and led holds.
  - BLINK:
    - If cnt==heff-1: cnt<=0 and led<=~led.
    - Otherwise: cnt<=cnt+1.
  - ONESHOT:
    - If cnt==heff-1: led<=0, mode<=OFF, cnt<=0, and oneshot_done[i]=1 for exactly that following cycle.
    - Otherwise: cnt<=cnt+1.
- Latency from a write to the first toggle or end: between (heff-1)*PRESCALE+1 and heff*PRESCALE enabled cycles. Phase depends on the prescaler position.
- Steady-state BLINK period: 2*heff*PRESCALE enabled cycles, 50% duty.
- Re-writing a channel mid-BLINK or mid-ONESHOT restarts it. A pending oneshot_done is cancelled and no pulse is emitted.
- Arithmetic is unsigned. cnt is CNT_W bits and never exceeds heff-1, so no wrap occurs.

Test Plan:
All scenarios use NUM_CH=4, PRESCALE=4, CNT_W=4.
1. Reset behaviour: hold rst=1 with wr_en=1 (ch0, BLINK) → led=0000 and oneshot_done=0000 throughout. After release, no channel is active.
2. BLINK timing: write ch0 BLINK, half=3, enable=1 → led[0]=1 on the next cycle. After the first toggle, led[0] toggles exactly every 12 cycles. Other bits stay 0.
3. ONESHOT: write ch2 ONESHOT, half=2 → led[2]=1 for 5..8 cycles. Then led[2]=0 and oneshot_done[2]=1 for exactly 1 cycle, coincident with the fall. No further activity follows.
4. Enable freeze: run ch1 BLINK half=1, then drop enable for 20 cycles mid-half → led[1] and the phase hold. The half-period containing the freeze lasts 4+20 cycles, and normal timing resumes afterwards.
5. Edge cases:
   - A write coinciding with a tick on ch3 → cnt restarts at 0 and the next toggle comes a full heff later.
   - half=0 behaves as 1, toggling every 4 cycles.
   - With NUM_CH=3, wr_ch=3 is ignored.
6. Reset mid-operation: ch0 BLINK and ch2 ONESHOT running, pulse rst for 1 cycle → all led=0, modes OFF, and no oneshot_done pulse appears.
